// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Conditions raw board push-buttons / switches for internal logic. Each
//   channel passes through a 2-flop synchronizer, then a stability counter
//   that accepts a new level only after it has held for DEBOUNCE_CYCLES
//   consecutive clocks. Acceptance updates the debounced level and fires a
//   one-cycle rise or fall pulse on the same edge.
//
// Ports
//   clk       in   1      system clock, rising edge
//   rst       in   1      synchronous, active-high reset
//   btn_in    in   WIDTH  raw asynchronous pin levels
//   btn_out   out  WIDTH  debounced level per channel
//   btn_rise  out  WIDTH  1-cycle pulse when btn_out goes 0->1
//   btn_fall  out  WIDTH  1-cycle pulse when btn_out goes 1->0
//   any_rise  out  1      OR of btn_rise, registered alongside it
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// button_debouncer_lane
//   One debounced channel.
//
// Ports
//   clk       in   1   system clock
//   rst       in   1   synchronous, active-high reset
//   btn_in    in   1   raw pin level
//   btn_out   out  1   debounced level
//   btn_rise  out  1   registered 0->1 pulse
//   btn_fall  out  1   registered 1->0 pulse
//   rise_set  out  1   combinational "rise fires at next edge" for the shared
//                      any_rise register in the top level
// ----------------------------------------------------------------------------
module button_debouncer_lane #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic btn_out,
   output logic btn_rise,
   output logic btn_fall,
   output logic rise_set
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync1;
   logic                 sync2;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 differ;
   logic                 accept;

   // Only the second synchronizer stage is ever compared against btn_out,
   // so metastability on sync1 never reaches the counter.
   assign differ   = (sync2 != btn_out);
   // Counter already holds N-1 differing samples and this is the Nth.
   assign accept   = differ && (cnt == CNT_MAX);
   assign rise_set = accept & sync2;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         btn_out  <= 1'b0;
         btn_rise <= 1'b0;
         btn_fall <= 1'b0;
         cnt      <= '0;
      end else begin
         sync1    <= btn_in;
         sync2    <= sync1;
         btn_rise <= accept &  sync2;
         btn_fall <= accept & ~sync2;
         if (accept) begin
            btn_out <= sync2;
            cnt     <= '0;
         end else if (differ) begin
            cnt     <= cnt + 1'b1;
         end else begin
            // Any sample matching the current level restarts the count.
            cnt     <= '0;
         end
      end
   end

endmodule

module button_debouncer #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] btn_in,
   output logic [WIDTH-1:0] btn_out,
   output logic [WIDTH-1:0] btn_rise,
   output logic [WIDTH-1:0] btn_fall,
   output logic             any_rise
);

   localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);

   // A one-cycle window cannot filter anything and collapses the counter
   // to zero bits, so refuse to build it.
   generate
      if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
         $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
      end
   endgenerate

   logic [WIDTH-1:0] rise_set;

   button_debouncer_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH)
   ) u_lane [WIDTH-1:0] (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_out  (btn_out),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .rise_set (rise_set)
   );

   // Built from the lanes' next-cycle rise terms so it lands on the very
   // edge the individual btn_rise pulses do.
   always_ff @(posedge clk) begin
      if (rst) any_rise <= 1'b0;
      else     any_rise <= |rise_set;
   end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

   localparam int W = 4;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] btn_in = '0;
   logic [W-1:0] btn_out, btn_rise, btn_fall;
   logic         any_rise;

   button_debouncer #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .btn_in   (btn_in),
      .btn_out  (btn_out),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall),
      .any_rise (any_rise)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endfunction

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [W-1:0] out;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         any;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] samp_q[$];   // input samples; the oldest is what the filter sees now
   logic [W-1:0] m_out = '0;
   int           run[W];      // consecutive filter samples differing from m_out

   always @(posedge clk) begin
      exp_t         e;
      logic [W-1:0] s;
      e = '0;
      if (rst) begin
         samp_q = '{4'b0000, 4'b0000};
         m_out  = '0;
         for (int i = 0; i < W; i++) run[i] = 0;
      end else begin
         s = samp_q.pop_front();
         samp_q.push_back(btn_in);
         for (int i = 0; i < W; i++) begin
            if (s[i] != m_out[i]) run[i]++;
            else                  run[i] = 0;
            if (run[i] == N) begin
               m_out[i] = s[i];
               run[i]   = 0;
               if (s[i]) e.rise[i] = 1'b1;
               else      e.fall[i] = 1'b1;
            end
         end
      end
      e.out = m_out;
      e.any = |e.rise;
      exp_q.push_back(e);
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_btn_out",  32'(btn_out),  32'(e.out));
         chk("sb_btn_rise", 32'(btn_rise), 32'(e.rise));
         chk("sb_btn_fall", 32'(btn_fall), 32'(e.fall));
         chk("sb_any_rise", 32'(any_rise), 32'(e.any));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Called right after an input change at edge+2; the next edge is E1.
   // Expects the accepted change at E(N+2) only.
   task automatic check_edge(input int ch, input bit rise_exp);
      repeat (N + 1) @(posedge clk);
      #1;
      chk("pre_out",   32'(btn_out[ch]), 32'(!rise_exp));
      chk("pre_pulse", 32'(btn_rise[ch] | btn_fall[ch]), 32'(0));
      @(posedge clk);
      #1;
      chk("edge_out",  32'(btn_out[ch]),  32'(rise_exp));
      chk("edge_rise", 32'(btn_rise[ch]), 32'(rise_exp));
      chk("edge_fall", 32'(btn_fall[ch]), 32'(!rise_exp));
      chk("edge_any",  32'(any_rise),     32'(rise_exp));
      @(posedge clk);
      #1;
      chk("post_pulse", 32'(btn_rise[ch] | btn_fall[ch]), 32'(0));
      #1;
   endtask

   int hold[W];

   initial begin
      // 1. reset, then quiet inputs
      step(3);
      rst = 1'b0;
      step(50);

      // 2. clean press on ch0
      btn_in[0] = 1'b1;
      check_edge(0, 1'b1);
      step(5);

      // 3. bounce on ch1, then settle high
      for (int k = 0; k < 10; k++) begin
         btn_in[1] = ~btn_in[1];
         step(3);
      end
      btn_in[1] = 1'b1;
      check_edge(1, 1'b1);
      step(5);

      // 4. release ch0
      btn_in[0] = 1'b0;
      check_edge(0, 1'b0);
      step(5);

      // 5. glitches on ch2: 7 cycles (filtered), 8 cycles (accepted)
      btn_in[2] = 1'b1; step(N - 1); btn_in[2] = 1'b0; step(20);
      btn_in[2] = 1'b1; step(N);     btn_in[2] = 1'b0; step(25);

      // 6. reset mid-count, then input held through reset
      btn_in = '0;
      step(20);
      btn_in[3] = 1'b1;
      step(2 + 5);
      rst = 1'b1;
      step(1);
      chk("rst_out",  32'(btn_out),  32'(0));
      chk("rst_rise", 32'(btn_rise), 32'(0));
      chk("rst_any",  32'(any_rise), 32'(0));
      step(2);
      rst = 1'b0;
      check_edge(3, 1'b1);
      btn_in = '0;
      step(20);

      // all four channels together
      btn_in = 4'b1111;
      repeat (N + 2) @(posedge clk);
      #1;
      chk("all_rise", 32'(btn_rise), 32'(4'hF));
      chk("all_any",  32'(any_rise), 32'(1));
      @(posedge clk);
      #1;
      chk("all_any_post", 32'(any_rise), 32'(0));
      #1;
      step(5);

      // random hold lengths per channel, with occasional resets
      for (int i = 0; i < W; i++) hold[i] = $urandom_range(14, 1);
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < W; i++) begin
            hold[i]--;
            if (hold[i] <= 0) begin
               btn_in[i] = ~btn_in[i];
               hold[i]   = $urandom_range(14, 1);
            end
         end
         rst = ($urandom_range(399, 0) == 0);
         step(1);
      end
      rst = 1'b0;
      step(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
